// File: rtl/fusion_pkg.sv
// fusion_pkg: shared state encoding and default widths for the fusion datapath
package fusion_pkg;
   localparam int FUSION_PROD_W = 16;
   localparam int DEF_PSUM_W    = FUSION_PROD_W;
   localparam int DEF_ACC_W     = 32;
   localparam int DEF_CNT_W     = 8;
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/psum_acc_adder.sv
// psum_acc_adder: extends a partial product to accumulator width and adds it, flagging overflow
//   i_psum   partial product from the fusion unit
//   i_acc    running accumulator value
//   i_signed 1 = operands are two's complement
//   o_sum    wrapped sum, ACC_W bits
//   o_ovf    signed or unsigned overflow of this addition
module psum_acc_adder #(
   parameter int PSUM_W = 16,
   parameter int ACC_W  = 32
) (
   input  logic [PSUM_W-1:0] i_psum,
   input  logic [ACC_W-1:0]  i_acc,
   input  logic              i_signed,
   output logic [ACC_W-1:0]  o_sum,
   output logic              o_ovf
);
   logic [ACC_W-1:0] w_ext;
   logic             w_carry;
   always_comb begin
      w_ext = i_signed ? {{(ACC_W-PSUM_W){i_psum[PSUM_W-1]}}, i_psum} : {{(ACC_W-PSUM_W){1'b0}}, i_psum};
      {w_carry, o_sum} = {1'b0, i_acc} + {1'b0, w_ext};
      // signed: like-signed operands producing a result of the other sign
      o_ovf = i_signed ? (i_acc[ACC_W-1] == w_ext[ACC_W-1]) && (o_sum[ACC_W-1] != i_acc[ACC_W-1]) : w_carry;
   end
endmodule

// File: rtl/fusion_psum_accumulator.sv
// fusion_psum_accumulator: sums a programmed number of fusion-unit products and hands the result downstream
//   cfg_start/cfg_num_terms/cfg_signed  run configuration, honoured only when idle
//   psum_in/psum_valid/psum_ready       incoming products (ready depends on state only)
//   acc_out/acc_out_valid/acc_out_ready result port, held until accepted
//   busy                                any state other than IDLE
//   overflow                            sticky overflow of the current run
module fusion_psum_accumulator
   import fusion_pkg::*;
#(
   parameter int PSUM_W = DEF_PSUM_W,
   parameter int ACC_W  = DEF_ACC_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_start,
   input  logic [CNT_W-1:0]  cfg_num_terms,
   input  logic              cfg_signed,
   input  logic [PSUM_W-1:0] psum_in,
   input  logic              psum_valid,
   output logic              psum_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic              acc_out_valid,
   input  logic              acc_out_ready,
   output logic              busy,
   output logic              overflow
);
   state_t           r_state;
   logic [ACC_W-1:0] r_acc, r_acc_out;
   logic [CNT_W-1:0] r_count, r_num;
   logic             r_signed, r_valid, r_ovf;
   logic [ACC_W-1:0] w_sum;
   logic             w_ovf, w_last;

   psum_acc_adder #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) u_adder (
      .i_psum  (psum_in),
      .i_acc   (r_acc),
      .i_signed(r_signed),
      .o_sum   (w_sum),
      .o_ovf   (w_ovf)
   );

   assign psum_ready    = r_state == ACCUM;
   assign busy          = r_state != IDLE;
   assign acc_out       = r_acc_out;
   assign acc_out_valid = r_valid;
   assign overflow      = r_ovf;
   // r_num >= 1 whenever ACCUM is entered, so this never wraps
   assign w_last        = (r_count + CNT_W'(1)) == r_num;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_acc     <= '0;
         r_count   <= '0;
         r_num     <= '0;
         r_signed  <= 1'b0;
         r_acc_out <= '0;
         r_valid   <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (cfg_start) begin
               r_num    <= cfg_num_terms;
               r_signed <= cfg_signed;
               r_acc    <= '0;
               r_count  <= '0;
               r_ovf    <= 1'b0;
               if (cfg_num_terms == '0) begin
                  r_state   <= DONE;
                  r_acc_out <= '0;
                  r_valid   <= 1'b1;
               end else begin
                  r_state <= ACCUM;
               end
            end
            ACCUM: if (psum_valid && psum_ready) begin
               r_acc   <= w_sum;
               r_count <= r_count + CNT_W'(1);
               r_ovf   <= r_ovf | w_ovf;
               if (w_last) begin
                  r_state   <= DONE;
                  r_acc_out <= w_sum;
                  r_valid   <= 1'b1;
               end
            end
            DONE: if (acc_out_ready) begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fusion_psum_accumulator.sv
// tb_fusion_psum_accumulator: directed table plus randomized runs against a 32-bit and a 17-bit accumulator
module tb_fusion_psum_accumulator;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_start = 1'b0;
   logic [7:0]  cfg_num_terms = '0;
   logic        cfg_signed = 1'b0;
   logic [15:0] psum_in = '0;
   logic        psum_valid = 1'b0;
   logic        acc_out_ready = 1'b0;
   logic        rdy32, v32, busy32, ovf32, rdy17, v17, busy17, ovf17;
   logic [31:0] acc32;
   logic [16:0] acc17;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   fusion_psum_accumulator d32 (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_terms(cfg_num_terms),
      .cfg_signed(cfg_signed), .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(rdy32),
      .acc_out(acc32), .acc_out_valid(v32), .acc_out_ready(acc_out_ready), .busy(busy32),
      .overflow(ovf32));

   fusion_psum_accumulator #(.ACC_W(17)) d17 (
      .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_terms(cfg_num_terms),
      .cfg_signed(cfg_signed), .psum_in(psum_in), .psum_valid(psum_valid), .psum_ready(rdy17),
      .acc_out(acc17), .acc_out_valid(v17), .acc_out_ready(acc_out_ready), .busy(busy17),
      .overflow(ovf17));

   typedef struct {
      int               n;
      bit               sgn;
      logic [3:0][15:0] ps;
      int               gap;
      int               hold;
      logic [31:0]      e32;
      bit               o32;
      logic [16:0]      e17;
      bit               o17;
   } vec_t;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: exact integer sums, overflow when the true result leaves the w-bit range
   function automatic void model(input int w, input bit sgn, input logic [15:0] ps[$],
                                 output longint sum, output bit ovf);
      longint m = longint'(1) <<< w;
      longint half = m / 2;
      longint acc = 0;
      longint e, a, t;
      ovf = 1'b0;
      foreach (ps[i]) begin
         e = sgn ? longint'($signed(ps[i])) : longint'({48'd0, ps[i]});
         a = (sgn && acc >= half) ? acc - m : acc;
         t = a + e;
         if (sgn ? (t < -half || t >= half) : (t >= m)) ovf = 1'b1;
         acc = t & (m - 1);
      end
      sum = acc;
   endfunction

   task automatic do_run(input int n, input bit sgn, input logic [15:0] ps[$], input int gap,
                         input int hold, input logic [31:0] e32, input bit o32,
                         input logic [16:0] e17, input bit o17);
      cfg_num_terms = 8'(n);
      cfg_signed = sgn;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      for (int i = 0; i < n; i++) begin
         psum_valid = 1'b0;
         for (int g = 0; g < gap; g++) begin
            psum_in = 16'($urandom);
            step();
         end
         check("psum_ready_accum", 64'(rdy32), 64'(1));
         check("busy_accum", 64'(busy32), 64'(1));
         check("no_early_valid", 64'(v32), 64'(0));
         psum_in = ps[i];
         psum_valid = 1'b1;
         step();
         psum_valid = 1'b0;
      end
      check("valid32", 64'(v32), 64'(1));
      check("acc32", 64'(acc32), 64'(e32));
      check("ovf32", 64'(ovf32), 64'(o32));
      check("valid17", 64'(v17), 64'(1));
      check("acc17", 64'(acc17), 64'(e17));
      check("ovf17", 64'(ovf17), 64'(o17));
      check("psum_ready_done", 64'(rdy32), 64'(0));
      psum_valid = 1'b1;
      cfg_start = 1'b1;
      for (int h = 0; h < hold; h++) begin
         psum_in = 16'($urandom);
         step();
         check("hold_acc32", 64'(acc32), 64'(e32));
         check("hold_ovf17", 64'(ovf17), 64'(o17));
         check("hold_valid", 64'(v32), 64'(1));
         check("hold_ready", 64'(rdy32 | rdy17), 64'(0));
      end
      cfg_start = 1'b0;
      psum_valid = 1'b0;
      acc_out_ready = 1'b1;
      step();
      acc_out_ready = 1'b0;
      check("idle_valid", 64'(v32 | v17), 64'(0));
      check("idle_busy", 64'(busy32 | busy17), 64'(0));
      check("idle_acc_kept", 64'(acc32), 64'(e32));
   endtask

   initial begin
      vec_t        vt[7];
      logic [15:0] q[$];
      longint      s32, s17;
      bit          f32, f17;
      int          n;
      bit          sgn;
      vt[0] = '{3, 1'b0, {16'h0, 16'h0001, 16'h0010, 16'h00E1}, 2, 1, 32'h000000F2, 1'b0, 17'h000F2, 1'b0};
      vt[1] = '{2, 1'b1, {16'h0, 16'h0, 16'h0005, 16'hFFE2}, 0, 0, 32'hFFFFFFE7, 1'b0, 17'h1FFE7, 1'b0};
      vt[2] = '{0, 1'b0, {16'h0, 16'h0, 16'h0, 16'h0}, 0, 2, 32'h0, 1'b0, 17'h0, 1'b0};
      vt[3] = '{1, 1'b0, {16'h0, 16'h0, 16'h0, 16'h1234}, 0, 5, 32'h00001234, 1'b0, 17'h01234, 1'b0};
      vt[4] = '{3, 1'b0, {16'h0, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 1, 0, 32'h0002FFFD, 1'b0, 17'h0FFFD, 1'b1};
      vt[5] = '{3, 1'b1, {16'h0, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 0, 0, 32'h00017FFD, 1'b0, 17'h17FFD, 1'b1};
      vt[6] = '{2, 1'b1, {16'h0, 16'h0, 16'h8000, 16'h8000}, 0, 1, 32'hFFFF0000, 1'b0, 17'h10000, 1'b0};
      step();
      step();
      check("rst_valid", 64'(v32 | v17), 64'(0));
      check("rst_acc", 64'(acc32), 64'(0));
      check("rst_ready_busy", 64'({rdy32, busy32, ovf32}), 64'(0));
      rst = 1'b0;
      step();
      foreach (vt[k]) begin
         q = {};
         for (int i = 0; i < vt[k].n; i++) q.push_back(vt[k].ps[i]);
         do_run(vt[k].n, vt[k].sgn, q, vt[k].gap, vt[k].hold, vt[k].e32, vt[k].o32, vt[k].e17, vt[k].o17);
      end
      // abort mid-run: partial sum must be discarded
      cfg_num_terms = 8'd3;
      cfg_signed = 1'b0;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      psum_in = 16'h0004;
      psum_valid = 1'b1;
      step();
      psum_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_outputs", 64'({v32, rdy32, busy32, ovf32}), 64'(0));
      check("abort_acc", 64'(acc32), 64'(0));
      q = {16'h0004, 16'h0004};
      do_run(2, 1'b0, q, 0, 0, 32'h8, 1'b0, 17'h8, 1'b0);
      for (int r = 0; r < 25; r++) begin
         n = $urandom_range(1, 8);
         sgn = 1'($urandom);
         q = {};
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 4))
               0: q.push_back(16'hFFFF);
               1: q.push_back(16'h7FFF);
               2: q.push_back(16'h8000);
               default: q.push_back(16'($urandom));
            endcase
         end
         model(32, sgn, q, s32, f32);
         model(17, sgn, q, s17, f17);
         do_run(n, sgn, q, $urandom_range(0, 2), $urandom_range(0, 3), 32'(s32), f32, 17'(s17), f17);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fusion_psum_accumulator.md
Name: fusion_psum_accumulator

Overview:
- Consumer-side counterpart of the fusion unit. Accepts the 16-bit `psum_fwd` products over a valid/ready handshake.
- Extends each product to the accumulator width: sign-extend if the product is signed, else zero-extend.
- Accumulates a programmed number of terms, then presents the sum on a valid/ready output port.
- Sits between a fusion-unit column and the output buffer / writeback path.

Parameters:
- PSUM_W, 16: width of incoming partial product (matches fusion unit `psum_fwd`).
- ACC_W, 32: accumulator and result width; must be at least PSUM_W+1.
- CNT_W, 8: width of term counter; max terms per accumulation is 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  pulse; begins an accumulation. Honoured only in IDLE.
- cfg_num_terms  in  CNT_W  number of psums to accumulate; sampled with cfg_start.
- cfg_signed  in  1  1 = psums are two's complement (s_in|s_weight upstream); sampled with cfg_start.
- psum_in  in  PSUM_W  partial product from fusion unit.
- psum_valid  in  1  psum_in valid.
- psum_ready  out  1  block can accept psum_in this cycle.
- acc_out  out  ACC_W  accumulated result.
- acc_out_valid  out  1  acc_out valid.
- acc_out_ready  in  1  downstream accepts acc_out.
- busy  out  1  high in any state other than IDLE.
- overflow  out  1  sticky; set if any addition in the current run overflowed ACC_W.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, acc=0, count=0, acc_out=0, acc_out_valid=0, psum_ready=0, busy=0, overflow=0. Reset in any state aborts the run; partial sum is discarded.
- States: IDLE, ACCUM, DONE.
- IDLE, cfg_start=1:
  - Latch cfg_num_terms and cfg_signed; clear acc, count and overflow.
  - If cfg_num_terms==0, go to DONE (acc_out=0, acc_out_valid=1 the next cycle).
  - Otherwise go to ACCUM.
- ACCUM:
  - psum_ready=1, driven combinationally from state only, never from psum_valid.
  - Transfer occurs when psum_valid & psum_ready: acc <= acc + ext(psum_in); count <= count+1.
  - A transfer when count==num_terms-1 moves to DONE. The final sum appears on acc_out with acc_out_valid=1 in the cycle after that transfer (1-cycle latency).
  - psum_valid gaps are allowed; no transfer means acc and count hold.
- DONE:
  - acc_out_valid=1; acc_out and overflow stay stable until acc_out_ready=1.
  - On acc_out_ready=1, go to IDLE next cycle with acc_out_valid=0. acc_out keeps its last value.
  - psum_ready=0.
- cfg_start while busy is ignored; no queuing.
- Extension rule: ext(x) = sign-extend x to ACC_W when the latched signed flag is 1, else zero-extend.
- Arithmetic wraps modulo 2^ACC_W.
- Overflow detection:
  - Signed: both operands have the same sign and the sum's sign differs.
  - Unsigned: carry out of bit ACC_W-1.
  - Flag is sticky for the run and cleared on the next accepted cfg_start.
- acc_out_valid never asserts outside DONE. busy == (state != IDLE).

Decomposition:
- Shared package fusion_pkg: state enum (IDLE/ACCUM/DONE), default widths PSUM_W/ACC_W/CNT_W; the fusion unit's product width is defined there too.
- One sub-module: psum_acc_adder, combinational. Takes psum, acc and signed flag; produces the extended sum and an overflow bit. The parent holds the FSM, counter and registers.

Test Plan:
1. Unsigned, num_terms=3, psums 0x00E1, 0x0010, 0x0001 with a 2-cycle psum_valid gap -> acc_out=0x000000F2, overflow=0, valid exactly 1 cycle after third transfer.
2. Signed, num_terms=2, psums 0xFFE2 (-30), 0x0005 -> acc_out=0xFFFFFFE7 (-25), overflow=0.
3. num_terms=0 with cfg_start -> next cycle acc_out_valid=1, acc_out=0, psum_ready never asserts.
4. DONE with acc_out_ready low 5 cycles, psum_valid=1 and cfg_start pulsed -> acc_out stable, psum_ready=0, start ignored; ready=1 -> IDLE next cycle.
5. ACC_W=17, unsigned, num_terms=3, psums 0xFFFF x3 -> acc_out=0x0FFFD, overflow=1; next run clears overflow.
6. rst asserted in ACCUM after 1 transfer -> all outputs at reset values next cycle; a fresh run of 2 x 0x0004 yields 0x00000008.
